// File: rtl/ristretto_imem_arbiter_if.sv
// ristretto_imem_arbiter_if: fetch, load-store and shared-memory signals around the imem arbiter
interface ristretto_imem_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                   if_req_i;
   logic [AddrWidth-1:0]   if_addr_i;
   logic                   if_flush_i;
   logic                   if_gnt_o;
   logic                   if_rvalid_o;
   logic [DataWidth-1:0]   if_rdata_o;
   logic                   ls_req_i;
   logic                   ls_we_i;
   logic [AddrWidth-1:0]   ls_addr_i;
   logic [DataWidth/8-1:0] ls_be_i;
   logic [DataWidth-1:0]   ls_wdata_i;
   logic                   ls_gnt_o;
   logic                   ls_rvalid_o;
   logic [DataWidth-1:0]   ls_rdata_o;
   logic                   mem_req_o;
   logic                   mem_we_o;
   logic [AddrWidth-1:0]   mem_addr_o;
   logic [DataWidth/8-1:0] mem_be_o;
   logic [DataWidth-1:0]   mem_wdata_o;
   logic                   mem_gnt_i;
   logic                   mem_rvalid_i;
   logic [DataWidth-1:0]   mem_rdata_i;

   modport master (
      output if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );
endinterface

// File: rtl/ristretto_imem_arbiter.sv
// ristretto_imem_arbiter: shares one memory port between fetch and load-store with lock, anti-starvation and in-order response routing
module ristretto_imem_arbiter #(
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 2,
   parameter int StarveLimit    = 4
) (
   input logic                     clk_i,
   input logic                     rst_i,
   ristretto_imem_arbiter_if.slave bus
);
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam int PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
   localparam int StW  = $clog2(StarveLimit + 1);
   localparam logic [CntW-1:0] MaxCnt    = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] PtrLast   = PtrW'(MaxOutstanding - 1);
   localparam logic [StW-1:0]  StarveMax = StW'(StarveLimit);

   logic                      r_lock, r_lock_ls;
   logic [StW-1:0]            r_starve;
   logic [MaxOutstanding-1:0] r_owner_ls, r_kill;
   logic [PtrW-1:0]           r_wptr, r_rptr;
   logic [CntW-1:0]           r_count;
   logic w_if_req, w_lock, w_pick_if, w_sel_ls, w_sel_req, w_pop, w_req, w_grant, w_head_ls, w_head_kill;

   // Arbitration with lock override and flush masking, tracker-full gating, response head decode
   always_comb begin
      w_if_req    = bus.if_req_i & ~bus.if_flush_i;
      w_lock      = r_lock & (r_lock_ls | ~bus.if_flush_i);
      w_pick_if   = w_if_req & (~bus.ls_req_i | (r_starve == StarveMax));
      w_sel_ls    = w_lock ? r_lock_ls : ~w_pick_if;
      w_sel_req   = w_sel_ls ? bus.ls_req_i : w_if_req;
      w_pop       = bus.mem_rvalid_i & (r_count != '0);
      w_req       = w_sel_req & ~((r_count == MaxCnt) & ~w_pop);
      w_grant     = w_req & bus.mem_gnt_i;
      w_head_ls   = r_owner_ls[r_rptr];
      w_head_kill = r_kill[r_rptr];
   end

   assign bus.mem_req_o   = w_req;
   assign bus.mem_we_o    = w_req & w_sel_ls & bus.ls_we_i;
   assign bus.mem_addr_o  = w_req ? (w_sel_ls ? bus.ls_addr_i : bus.if_addr_i) : {AddrWidth{1'b0}};
   assign bus.mem_be_o    = w_req ? (w_sel_ls ? bus.ls_be_i : '1) : '0;
   assign bus.mem_wdata_o = (w_req & w_sel_ls) ? bus.ls_wdata_i : {DataWidth{1'b0}};
   assign bus.if_gnt_o    = w_grant & ~w_sel_ls;
   assign bus.ls_gnt_o    = w_grant & w_sel_ls;
   assign bus.if_rvalid_o = w_pop & ~w_head_ls & ~w_head_kill & ~bus.if_flush_i;
   assign bus.ls_rvalid_o = w_pop & w_head_ls & ~w_head_kill;
   assign bus.if_rdata_o  = bus.mem_rdata_i;
   assign bus.ls_rdata_o  = bus.mem_rdata_i;

   // Hold the selected owner while its request waits for a memory grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock    <= 1'b0;
         r_lock_ls <= 1'b0;
      end else begin
         r_lock    <= (w_lock ? w_sel_req : w_req) & ~w_grant;
         r_lock_ls <= w_sel_ls;
      end
   end

   // Count consecutive denied fetch cycles, saturating at the forced-priority threshold
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_starve <= '0;
      else
         r_starve <= (bus.if_req_i & ~bus.if_gnt_o & ~bus.if_flush_i) ?
                     ((r_starve == StarveMax) ? r_starve : r_starve + 1'b1) : '0;
   end

   // In-order tracker of granted requests; a flush marks every fetch entry for silent drop
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_kill     <= '0;
         r_owner_ls <= '0;
      end else begin
         for (int k = 0; k < MaxOutstanding; k++)
            if (bus.if_flush_i && !r_owner_ls[k]) r_kill[k] <= 1'b1;
         if (w_grant) begin
            r_owner_ls[r_wptr] <= w_sel_ls;
            r_kill[r_wptr]     <= bus.if_flush_i & ~w_sel_ls;
            r_wptr             <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
         r_count <= r_count + CntW'(w_grant) - CntW'(w_pop);
      end
   end
endmodule

// File: doc/ristretto_imem_arbiter.md
RISTRETTO_IMEM_ARBITER -- requirements
Module: ristretto_imem_arbiter

Interface
REQ-001 Parameter AddrWidth, default 32, address width of all ports.
REQ-002 Parameter DataWidth, default 32, data width; byte enables are DataWidth/8 bits.
REQ-003 Parameter MaxOutstanding, default 2, range 1..4, depth of the granted-not-responded tracker.
REQ-004 Parameter StarveLimit, default 4, consecutive denied fetch cycles before fetch gets forced priority.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 if_req_i / if_addr_i  in  1 / AddrWidth  fetch-unit read request and word address.
REQ-008 if_flush_i  in  1  fetch redirect (trap/control hazard); discards all fetch traffic in flight.
REQ-009 if_gnt_o / if_rvalid_o / if_rdata_o  out  1 / 1 / DataWidth  fetch grant, response valid, response data.
REQ-010 ls_req_i / ls_we_i / ls_addr_i / ls_be_i / ls_wdata_i  in  1 / 1 / AddrWidth / DataWidth/8 / DataWidth  load-store request.
REQ-011 ls_gnt_o / ls_rvalid_o / ls_rdata_o  out  1 / 1 / DataWidth  load-store grant, response valid, response data.
REQ-012 mem_req_o / mem_we_o / mem_addr_o / mem_be_o / mem_wdata_o  out  1 / 1 / AddrWidth / DataWidth/8 / DataWidth  shared memory port request.
REQ-013 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / DataWidth  memory grant, response valid, response data.

Function
REQ-014 Arbitration is combinational and applies only while no owner is locked: ls beats if, unless the starve counter equals StarveLimit, in which case if wins.
REQ-015 mem_* request fields are a combinational mux of the selected requester; a fetch request drives mem_we_o=0, mem_be_o all-ones, mem_wdata_o=0.
REQ-016 Lock: when mem_req_o=1 and mem_gnt_i=0, the selected owner is registered and keeps the port on following cycles until granted; the other requester stays blocked.
REQ-017 Grant forwarding: if_gnt_o / ls_gnt_o = mem_gnt_i & mem_req_o & (owner is that requester); never both high in one cycle.
REQ-018 The lock is released in the cycle of the grant; re-arbitration happens in the next cycle.
REQ-019 Starve counter: increments (saturating at StarveLimit) each cycle with if_req_i=1 and no if grant; clears on if grant, on if_flush_i, and whenever if_req_i=0.
REQ-020 Tracker: FIFO of MaxOutstanding entries {owner, kill}; push {owner, 0} on every forwarded grant; pop on mem_rvalid_i; responses return in order.
REQ-021 Full: with count==MaxOutstanding and mem_rvalid_i=0, mem_req_o=0 and no grant passes; with mem_rvalid_i=1 in the same cycle, the request is allowed (simultaneous push+pop, count unchanged).
REQ-022 Response routing: on mem_rvalid_i with head entry owner=if and kill=0, if_rvalid_o=1; owner=ls gives ls_rvalid_o=1; kill=1 gives no rvalid to anyone (silent drop).
REQ-023 if_rdata_o and ls_rdata_o are both driven from mem_rdata_i unconditionally; only the rvalids qualify them.
REQ-024 Flush: if_flush_i sets kill=1 on all if entries in the tracker, including one pushed in the same cycle; it also releases an if-owned lock and forces if out of arbitration that cycle (mem_req_o drops unless ls requests).
REQ-025 ls entries and an ls-owned lock are unaffected by if_flush_i.
REQ-026 Pop and flush in the same cycle: the popped entry is dropped if it is if-owned; the remaining if entries are killed.
REQ-027 mem_rvalid_i with an empty tracker is ignored: no rvalid out, count stays 0.
REQ-028 Pointers wrap modulo MaxOutstanding; count is $clog2(MaxOutstanding+1) bits and never exceeds MaxOutstanding.

Reset
REQ-029 While rst_i=1 at a clock edge: tracker empty (count=0, pointers 0, kill bits 0), lock cleared, starve counter 0.
REQ-030 During and after reset with no requests, all outputs are 0 (rdata outputs follow mem_rdata_i); reset mid-transaction discards all outstanding entries, and later mem_rvalid_i is ignored per REQ-027.

Verification
V-1 if_req_i=1 and ls_req_i=1 continuously, mem_gnt_i=1, StarveLimit=4 -> ls granted 4 cycles, if granted on the 5th, then ls again.
V-2 ls_req_i=1 with mem_gnt_i=0 for 3 cycles, if_req_i rises in cycle 2 -> mem_addr_o holds ls_addr_i all 3 cycles; if granted only after the ls grant.
V-3 MaxOutstanding=2: two if grants, no rvalid -> mem_req_o=0; rvalid plus a new request in one cycle -> grant given, count stays 2.
V-4 Two if entries outstanding, pulse if_flush_i, then 2 mem_rvalid_i -> if_rvalid_o stays 0 and count returns to 0; a following if request completes normally.
V-5 Order ls, if, ls outstanding, flush, 3 rvalids -> ls_rvalid_o on the 1st and 3rd only.
V-6 Assert rst_i with 2 outstanding, release, then mem_rvalid_i=1 -> no rvalid out, count=0, mem_req_o=0.
